// File: rtl/bmm_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bmm_modexp_ctrl
// Purpose  : Left-to-right square-and-multiply sequencer computing
//            base^exp mod modulus on top of the Barrett/Karatsuba modular
//            multiplier pipeline. The multiplier has no handshake, so a
//            fixed-latency wait counter times every product.
// Revision : 1.0  initial release
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request, sampled only in IDLE
//   base/exp/modulus/barrett_const   operation inputs, latched on start
//   busy           operation in progress
//   done           one-cycle completion pulse
//   result         base^exp mod modulus, held until the next completion
//   mul_a/mul_b    multiplier operands
//   mul_m          multiplier modulus
//   mul_const      multiplier Barrett constant
//   mul_z          reduced product returned by the multiplier
//
// Optional build macro
//   BMM_MODEXP_CONST_TIME_EN : a multiply follows every square; for zero
//   exponent bits the product is discarded, so timing and the operand
//   sequence are exponent-independent.
// ============================================================================
module bmm_modexp_ctrl #(
  parameter int N       = 32,
  parameter int E_W     = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     base,
  input  logic [E_W-1:0]   exp,
  input  logic [N-1:0]     modulus,
  input  logic [2*N-1:0]   barrett_const,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic [N-1:0]     mul_m,
  output logic [2*N-1:0]   mul_const,
  input  logic [N-1:0]     mul_z
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam int IDX_W = (E_W < 2) ? 1 : $clog2(E_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(E_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [N-1:0]     r;
  logic [N-1:0]     base_q;
  logic [E_W-1:0]   exp_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic             bit_set;
  logic             mul_next;   // a multiply window follows the current square
  logic [N-1:0]     prod;       // value R takes at the end of this window

  always_comb begin
    bit_set = exp_q[idx];
`ifdef BMM_MODEXP_CONST_TIME_EN
    mul_next = 1'b1;
    // Dummy multiply for a zero bit: product is computed but R is kept.
    prod     = ((state == MUL) && !bit_set) ? r : mul_z;
`else
    mul_next = bit_set;
    prod     = mul_z;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      mul_const <= '0;
      r         <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q    <= base;
            exp_q     <= exp;
            idx       <= IDX_TOP;
            busy      <= 1'b1;
            mul_m     <= modulus;
            mul_const <= barrett_const;
            cnt       <= CNT_LOAD;
            if (~|modulus[N-1:1]) begin
              // Modulus 0 or 1: result is 0 without touching the multiplier.
              r     <= '0;
              state <= DONE;
            end else begin
              // First square of R=1; operands go out with the state change.
              r     <= N'(1);
              mul_a <= N'(1);
              mul_b <= N'(1);
              state <= SQR;
            end
          end
        end

        SQR, MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // mul_z is valid now; forward it straight into the next operands
            // so they are stable from the first cycle of the next window.
            r     <= prod;
            cnt   <= CNT_LOAD;
            mul_a <= prod;
            if ((state == SQR) && mul_next) begin
              mul_b <= base_q;
              state <= MUL;
            end else if (idx == '0) begin
              result <= prod;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              idx   <= idx - IDX_W'(1);
              mul_b <= prod;
              state <= SQR;
            end
          end
        end

        DONE: begin
          // Entered with done already set from a finished loop; the trivial
          // modulus path enters with done clear and raises it here.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            result <= r;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmm_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmm_modexp_ctrl
// Purpose  : Self-checking bench for bmm_modexp_ctrl with a behavioural
//            MUL_LAT-stage modular multiplier and a result/latency scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_bmm_modexp_ctrl;
  localparam int N       = 32;
  localparam int E_W     = 32;
  localparam int MUL_LAT = 5;
  localparam int OP      = MUL_LAT + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     base_in = '0;
  logic [E_W-1:0]   exp_in = '0;
  logic [N-1:0]     mod_in = '0;
  logic [2*N-1:0]   bc_in = '0;
  logic             busy, done;
  logic [N-1:0]     result, mul_a, mul_b, mul_m, mul_z;
  logic [2*N-1:0]   mul_const;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [N-1:0] res;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  bmm_modexp_ctrl #(.N(N), .E_W(E_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base_in), .exp(exp_in),
    .modulus(mod_in), .barrett_const(bc_in), .busy(busy), .done(done),
    .result(result), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_const(mul_const), .mul_z(mul_z)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: product valid MUL_LAT edges after operands settle.
  logic [N-1:0] pipe [0:MUL_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= (mul_m == '0) ? '0 : N'((64'(mul_a) * 64'(mul_b)) % 64'(mul_m));
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_z = pipe[MUL_LAT-1];

  function automatic logic [N-1:0] modexp(logic [N-1:0] b, logic [E_W-1:0] e, logic [N-1:0] m);
    logic [63:0] acc;
    if (m < 2) return '0;
    acc = 64'd1;
    for (int i = E_W - 1; i >= 0; i--) begin
      acc = (acc * acc) % 64'(m);
      if (e[i]) acc = (acc * 64'(b)) % 64'(m);
    end
    return N'(acc);
  endfunction

  function automatic int latency(logic [E_W-1:0] e, logic [N-1:0] m);
    if (m < 2) return 2;
`ifdef BMM_MODEXP_CONST_TIME_EN
    return OP * 2 * E_W + 1;
`else
    return OP * (E_W + $countones(e)) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Runs one operation. poke_at>0 pulses a second start at that cycle;
  // rst_at>0 asserts reset at that cycle and abandons the operation.
  task automatic run_op(input logic [N-1:0] b, input logic [E_W-1:0] e,
                        input logic [N-1:0] m, input int poke_at, input int rst_at);
    exp_t x, y;
    int   busy_err;
    bit   seen;
    bit   aborted;
    logic [2*N-1:0] bc;
    busy_err = 0;
    seen     = 1'b0;
    aborted  = 1'b0;
    bc       = {$urandom, $urandom};
    x.res    = modexp(b, e, m);
    x.cyc    = latency(e, m);
    sb.push_back(x);
    @(negedge clk);
    base_in = b; exp_in = e; mod_in = m; bc_in = bc; start = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        check("mul_m", 64'(mul_m), 64'(m));
        check("mul_const", mul_const, bc);
      end
      if (k == poke_at) begin
        start = 1'b1; base_in = b + 1; exp_in = ~e; mod_in = m - 2;
      end
      if (k == poke_at + 1) start = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_result", 64'(result), 0);
        check("rst_mul_a", 64'(mul_a), 0);
        check("rst_mul_b", 64'(mul_b), 0);
        check("rst_mul_m", 64'(mul_m), 0);
        check("rst_mul_const", mul_const, 0);
        void'(sb.pop_back());
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (done) seen = 1'b1;
        end
        check("rst_no_done", 64'(seen), 0);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (busy !== (k < x.cyc)) busy_err++;
      if (done) begin
        seen = 1'b1;
        y = sb.pop_front();
        check("result", 64'(result), 64'(y.res));
        check("done_cycle", 64'(k), 64'(y.cyc));
        break;
      end
    end
    if (!aborted) begin
      check("done_seen", 64'(seen), 1);
      if (!seen && sb.size() > 0) void'(sb.pop_front());
      check("busy_window", 64'(busy_err), 0);
      @(negedge clk);
      check("done_pulse", 64'(done), 0);
      check("result_hold", 64'(result), 64'(x.res));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_result", 64'(result), 0);
    check("reset_mul_a", 64'(mul_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 32'd7, 0, 0);
    run_op(32'h12345678, 32'd0, 32'hFFFFFFFB, 0, 0);
    run_op(32'd2, 32'hFFFFFFFA, 32'hFFFFFFFB, 0, 0);
    run_op(32'd5, 32'd7, 32'd1, 0, 0);
    run_op(32'd0, 32'd9, 32'd0, 0, 0);
    run_op(32'h0BADF00D, 32'hDEADBEEF, 32'hFFFFFFFB, 20, 0);
    run_op(32'd3, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 50);
    run_op(32'd3, 32'd5, 32'd7, 0, 0);
    run_op(32'd3, 32'h00000001, 32'h7FFFFFFF, 0, 0);
    run_op(32'd3, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 0);
    for (int t = 0; t < 2; t++) begin
      logic [N-1:0] m;
      m = $urandom | 32'h8000_0001;
      run_op($urandom % m, $urandom, m, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
